// File: rtl/sigproc_pkg.sv
// Shared types and default constants for the pulse-rate measurement slice.
package sigproc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam int unsigned TAPS_DEF    = 31;
  localparam int unsigned WINDOW_DEF  = 1500;
  localparam int unsigned CNT_W_DEF   = 10;
  localparam int unsigned REFRACT_DEF = 30;

endpackage

// File: rtl/refractory_timer.sv
// Sample-strobe down-counter that blocks further peaks after a counted one.
module refractory_timer
  import sigproc_pkg::*;
#(
  parameter int unsigned REFRACT = REFRACT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic tick,
  output logic busy
);

  localparam int unsigned W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic [W-1:0] cnt;

  // A load on the same strobe as the peak wins: that strobe is not a "further" one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(REFRACT);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pulse_rate_ctrl.sv
// Windowed peak-rate measurement controller: warm up the filter, count peaks, report.
// Optional refractory blanking is enabled by defining PEAK_REFRACT_EN.
module pulse_rate_ctrl
  import sigproc_pkg::*;
#(
  parameter int unsigned TAPS    = TAPS_DEF,
  parameter int unsigned WINDOW  = WINDOW_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned REFRACT = REFRACT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             sample_valid,
  input  logic             peak_det,
  output logic             filt_en,
  output logic             det_clr,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             sat
);

  localparam int unsigned SCNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] PK_MAX = '1;

  state_t            state;
  logic [SCNT_W-1:0] scnt;
  logic [CNT_W-1:0]  pk_cnt;
  logic              pk_sat;

  logic             active;
  logic             last_warm;
  logic             last_meas;
  logic             meas_entry;
  logic             refr_busy;
  logic             pk_take;
  logic             pk_full;
  logic [CNT_W-1:0] pk_nxt;
  logic             sat_nxt;

  assign active     = (state == ST_WARMUP) || (state == ST_MEASURE);
  assign filt_en    = sample_valid & active;
  assign det_clr    = (state == ST_IDLE) & start & ~abort & ~reset;
  assign busy       = (state != ST_IDLE);

  assign last_warm  = sample_valid && (scnt == SCNT_W'(TAPS - 1));
  assign last_meas  = sample_valid && (scnt == SCNT_W'(WINDOW - 1));
  assign meas_entry = (state == ST_WARMUP) && last_warm && !abort;

  // Next peak count, including a peak coincident with the closing sample.
  assign pk_take = (state == ST_MEASURE) && peak_det && !refr_busy;
  assign pk_full = (pk_cnt == PK_MAX);
  assign pk_nxt  = (pk_take && !pk_full) ? pk_cnt + CNT_W'(1) : pk_cnt;
  assign sat_nxt = pk_sat | (pk_take & pk_full);

`ifdef PEAK_REFRACT_EN
  refractory_timer #(
    .REFRACT (REFRACT)
  ) u_refract (
    .clk   (clk),
    .reset (reset),
    .clr   (meas_entry),
    .load  (pk_take),
    .tick  (sample_valid),
    .busy  (refr_busy)
  );
`else
  wire [31:0] unused_refract = 32'(REFRACT);
  assign refr_busy = 1'b0;
`endif

  // Abort from any non-idle state outranks every other transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      scnt         <= '0;
      pk_cnt       <= '0;
      pk_sat       <= 1'b0;
      result       <= '0;
      sat          <= 1'b0;
      result_valid <= 1'b0;
    end else if (abort && (state != ST_IDLE)) begin
      state        <= ST_IDLE;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state  <= ST_WARMUP;
            scnt   <= '0;
            pk_cnt <= '0;
            pk_sat <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (sample_valid) begin
            if (last_warm) begin
              state <= ST_MEASURE;
              scnt  <= '0;
            end else begin
              scnt <= scnt + SCNT_W'(1);
            end
          end
        end
        ST_MEASURE: begin
          pk_cnt <= pk_nxt;
          pk_sat <= sat_nxt;
          if (sample_valid) begin
            if (last_meas) begin
              state        <= ST_REPORT;
              scnt         <= '0;
              result       <= pk_nxt;
              sat          <= sat_nxt;
              result_valid <= 1'b1;
            end else begin
              scnt <= scnt + SCNT_W'(1);
            end
          end
        end
        ST_REPORT: begin
          if (result_valid && result_ready) begin
            state        <= ST_IDLE;
            result_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_rate_ctrl.sv
// Scoreboard bench for pulse_rate_ctrl with TAPS=4, WINDOW=10, CNT_W=4, REFRACT=3.
module tb_pulse_rate_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic             sample_valid;
  logic             peak_det;
  logic             filt_en;
  logic             det_clr;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             sat;

  typedef struct packed {
    logic [CNT_W-1:0] res;
    logic             sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  pulse_rate_ctrl #(
    .TAPS    (4),
    .WINDOW  (10),
    .CNT_W   (CNT_W),
    .REFRACT (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .sample_valid (sample_valid),
    .peak_det     (peak_det),
    .filt_en      (filt_en),
    .det_clr      (det_clr),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sat          (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard head.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1 && !prev) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got %0d with no expected entry", result);
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e.res));
          chk("sat", 32'(sat), 32'(e.sat));
        end
      end
      prev = (result_valid === 1'b1);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    chk("det_clr_on_start", 32'(det_clr), 32'd1);
    next_cyc();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  // One sample strobe followed by an idle gap cycle.
  task automatic sample(input logic pk, input logic exp_fe, input string name);
    sample_valid = 1'b1;
    peak_det     = pk;
    @(negedge clk);
    chk(name, 32'(filt_en), 32'(exp_fe));
    next_cyc();
    sample_valid = 1'b0;
    peak_det     = 1'b0;
    next_cyc();
  endtask

  task automatic run_txn(input logic [13:0] mask);
    pulse_start();
    for (int i = 0; i < 14; i++) sample(mask[i], 1'b1, "filt_en_active");
  endtask

  task automatic accept();
    chk("valid_held", 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    next_cyc();
    result_ready = 1'b0;
    chk("valid_cleared", 32'(result_valid), 32'd0);
    chk("idle_after_accept", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    sample_valid = 1'b0; peak_det = 1'b0; result_ready = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_filt_en", 32'(filt_en), 32'd0);
    chk("rst_det_clr", 32'(det_clr), 32'd0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    // Peaks on samples 6 and 9 -> 2; held until ready.
    e.res = 4'd2; e.sat = 1'b0; exp_q.push_back(e);
    run_txn(14'b00_0001_0010_0000);
    next_cyc();
    next_cyc();
    accept();

    // Peaks only in warm-up and report -> 0.
    e.res = 4'd0; e.sat = 1'b0; exp_q.push_back(e);
    run_txn(14'b00_0000_0000_1111);
    sample(1'b1, 1'b0, "filt_en_report");
    sample(1'b1, 1'b0, "filt_en_report");
    start = 1'b1;
    next_cyc();
    start = 1'b0;
    chk("report_result_stable", 32'(result), 32'd0);
    chk("start_ignored_in_report", 32'(result_valid), 32'd1);
    accept();

    // 20 peaks saturate the 4-bit count.
    e.res = 4'd15; e.sat = 1'b1; exp_q.push_back(e);
    pulse_start();
    for (int i = 0; i < 4; i++) sample(1'b0, 1'b1, "filt_en_warmup");
    for (int i = 0; i < 20; i++) begin
      peak_det = 1'b1;
      next_cyc();
      peak_det = 1'b0;
    end
    for (int i = 0; i < 10; i++) sample(1'b0, 1'b1, "filt_en_measure");
    accept();

    // Abort at measurement sample 7 keeps the previous result.
    pulse_start();
    for (int i = 0; i < 4; i++) sample(1'b0, 1'b1, "filt_en_warmup");
    for (int i = 0; i < 6; i++) sample(1'b1, 1'b1, "filt_en_measure");
    sample_valid = 1'b1;
    abort        = 1'b1;
    @(negedge clk);
    chk("filt_en_abort_cycle", 32'(filt_en), 32'd1);
    next_cyc();
    sample_valid = 1'b0;
    abort        = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_result_kept", 32'(result), 32'd15);
    chk("abort_sat_kept", 32'(sat), 32'd1);

    // Start together with abort in IDLE stays IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("det_clr_start_abort", 32'(det_clr), 32'd0);
    next_cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    next_cyc();

    // Peaks on samples 5, 6, 8, 9: refractory blanking drops 6 and 8.
`ifdef PEAK_REFRACT_EN
    e.res = 4'd2;
`else
    e.res = 4'd4;
`endif
    e.sat = 1'b0; exp_q.push_back(e);
    run_txn(14'b00_0001_1011_0000);
    accept();

    // Peak coincident with the window-closing sample counts.
    e.res = 4'd1; e.sat = 1'b0; exp_q.push_back(e);
    run_txn(14'b10_0000_0000_0000);
    accept();

    // Asynchronous reset mid-measurement.
    pulse_start();
    for (int i = 0; i < 7; i++) sample(i == 5, 1'b1, "filt_en_active");
    sample_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("midmeas_rst_busy", 32'(busy), 32'd0);
    chk("midmeas_rst_result", 32'(result), 32'd0);
    chk("midmeas_rst_filt_en", 32'(filt_en), 32'd0);
    chk("midmeas_rst_sat", 32'(sat), 32'd0);
    next_cyc();
    reset        = 1'b0;
    sample_valid = 1'b0;
    next_cyc();

    // First start after reset, then reset while a result is pending.
    e.res = 4'd1; e.sat = 1'b0; exp_q.push_back(e);
    run_txn(14'b00_0000_0100_0000);
    chk("pending_valid", 32'(result_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("report_rst_valid", 32'(result_valid), 32'd0);
    chk("report_rst_result", 32'(result), 32'd0);
    chk("report_rst_busy", 32'(busy), 32'd0);
    next_cyc();
    reset = 1'b0;
    next_cyc();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
